// File: rtl/multicycle_control_fsm_if.sv
// Memory request/ready handshake between the control sequencer and the memory system.
interface multicycle_control_fsm_if;
   logic mem_req;
   logic mem_we;
   logic mem_ready;

   modport master (output mem_req, output mem_we, input mem_ready);
   modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshake,
// datapath strobes, retired-instruction count and sticky trap on illegal opcode or bus timeout.
module multicycle_control_fsm #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [6:0]                   opcode,
   input  logic [2:0]                   funct3,
   input  logic [4:0]                   rd,
   multicycle_control_fsm_if.master     mem,
   output logic                         ir_write,
   output logic                         pc_write,
   output logic                         branch_eval,
   output logic                         alu_src_imm,
   output logic                         mem_to_reg,
   output logic                         reg_write,
   output logic [2:0]                   state,
   output logic                         trap,
   output logic                         bus_err,
   output logic [CNT_W-1:0]             retired
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [6:0]         op_q, op_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   retired_q;
   logic               trap_q, trap_d;
   logic               bus_err_q, bus_err_d;
   logic               ret_inc;

   logic               mem_req_c, mem_we_c, ir_write_c, pc_write_c, branch_eval_c;
   logic               alu_src_imm_c, mem_to_reg_c, reg_write_c;
   logic               op_supported;
   logic               unused_funct3;

   // The datapath resolves branch conditions itself, so funct3 is not needed here.
   assign unused_funct3 = ^funct3;

   assign op_supported = (opcode == OP_R)     || (opcode == OP_IALU)   ||
                         (opcode == OP_LOAD)  || (opcode == OP_STORE)  ||
                         (opcode == OP_BRANCH)|| (opcode == OP_LUI);

   // State register and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         wait_q    <= '0;
         retired_q <= '0;
         trap_q    <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         wait_q    <= wait_d;
         trap_q    <= trap_d;
         bus_err_q <= bus_err_d;
         if (ret_inc) begin
            retired_q <= retired_q + CNT_W'(1);
         end
      end
   end

   // Next state and combinational strobes
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      wait_d        = wait_q;
      trap_d        = trap_q;
      bus_err_d     = bus_err_q;
      ret_inc       = 1'b0;
      mem_req_c     = 1'b0;
      mem_we_c      = 1'b0;
      ir_write_c    = 1'b0;
      pc_write_c    = 1'b0;
      branch_eval_c = 1'b0;
      alu_src_imm_c = 1'b0;
      mem_to_reg_c  = 1'b0;
      reg_write_c   = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req_c = 1'b1;
            if (mem.mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               wait_d     = '0;
               state_d    = S_DECODE;
            end else if (wait_q == WAIT_LAST) begin
               state_d   = S_TRAP;
               trap_d    = 1'b1;
               bus_err_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_DECODE: begin
            op_d = opcode;
            if (op_supported) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
            end
         end
         S_EXEC: begin
            alu_src_imm_c = (op_q == OP_IALU) || (op_q == OP_LOAD) ||
                            (op_q == OP_STORE) || (op_q == OP_LUI);
            if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
               wait_d  = '0;
               state_d = S_MEM;
            end else if (op_q == OP_BRANCH) begin
               branch_eval_c = 1'b1;
               ret_inc       = 1'b1;
               wait_d        = '0;
               state_d       = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            mem_req_c     = 1'b1;
            mem_we_c      = (op_q == OP_STORE);
            alu_src_imm_c = 1'b1;
            if (mem.mem_ready) begin
               wait_d = '0;
               if (op_q == OP_STORE) begin
                  ret_inc = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_q == WAIT_LAST) begin
               state_d   = S_TRAP;
               trap_d    = 1'b1;
               bus_err_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_WB: begin
            reg_write_c  = (rd != 5'd0);
            mem_to_reg_c = (op_q == OP_LOAD);
            ret_inc      = 1'b1;
            wait_d       = '0;
            state_d      = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
         end
      endcase
   end

   // Strobes drop while reset is held, whatever state is still registered
   assign mem.mem_req = mem_req_c     & ~reset;
   assign mem.mem_we  = mem_we_c      & ~reset;
   assign ir_write    = ir_write_c    & ~reset;
   assign pc_write    = pc_write_c    & ~reset;
   assign branch_eval = branch_eval_c & ~reset;
   assign alu_src_imm = alu_src_imm_c & ~reset;
   assign mem_to_reg  = mem_to_reg_c  & ~reset;
   assign reg_write   = reg_write_c   & ~reset;

   assign state   = state_q;
   assign trap    = trap_q;
   assign bus_err = bus_err_q;
   assign retired = retired_q;

endmodule
